// File: rtl/bounce_sequencer.sv
// bounce_sequencer
// Moves a BOX_WIDTH x BOX_HEIGHT box around the visible screen area, one
// step per accepted frame_tick. The box bounces off the walls, and its
// colour advances once for each frame in which it touches a wall.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   frame_tick   one-cycle frame-boundary pulse (accepted only in IDLE)
//   enable       gates acceptance of frame_tick
//   speed_x/y    unsigned per-frame step sizes (each sampled in its own step state)
//   box_x/box_y  registered top-left corner of the box
//   color        registered {b,g,r} enable bits
//   busy         high while an update is in progress
//   update_done  one-cycle pulse after the colour stage of an update
module bounce_sequencer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BOX_WIDTH     = 100,
  parameter int BOX_HEIGHT    = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_tick,
  input  logic                             enable,
  input  logic [3:0]                       speed_x,
  input  logic [3:0]                       speed_y,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  box_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] box_y,
  output logic [2:0]                       color,
  output logic                             busy,
  output logic                             update_done
);

  localparam int XW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);

  // Limits are held one bit wider so they compare directly with the sums.
  localparam logic [XW:0] XMAX = (XW+1)'(SCREEN_WIDTH - BOX_WIDTH);
  localparam logic [YW:0] YMAX = (YW+1)'(SCREEN_HEIGHT - BOX_HEIGHT);

  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, RECOLOR} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   box_x_q, box_x_d;
  logic [YW-1:0]   box_y_q, box_y_d;
  logic            dir_x_q, dir_x_d;
  logic            dir_y_q, dir_y_d;
  logic            hit_x_q, hit_x_d;
  logic            hit_y_q, hit_y_d;
  logic [2:0]      color_q, color_d;
  logic            done_q, done_d;

  logic [XW:0]     spd_x_ext, sum_x;
  logic [YW:0]     spd_y_ext, sum_y;

  assign spd_x_ext = (XW+1)'(speed_x);
  assign spd_y_ext = (YW+1)'(speed_y);
  assign sum_x     = {1'b0, box_x_q} + spd_x_ext;
  assign sum_y     = {1'b0, box_y_q} + spd_y_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      box_x_q <= XW'(50);
      box_y_q <= YW'(50);
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
      color_q <= 3'b111;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hit_x_q <= hit_x_d;
      hit_y_q <= hit_y_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;
    color_d = color_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick && enable) state_d = STEP_X;
      end

      STEP_X: begin
        state_d = STEP_Y;
        hit_x_d = 1'b0;
        // A zero speed never moves the box, so it can never register a hit.
        if (speed_x != 4'd0) begin
          if (dir_x_q) begin
            if (sum_x >= XMAX) begin
              box_x_d = XMAX[XW-1:0];
              dir_x_d = 1'b0;
              hit_x_d = 1'b1;
            end else begin
              box_x_d = sum_x[XW-1:0];
            end
          end else begin
            if ({1'b0, box_x_q} <= spd_x_ext) begin
              box_x_d = '0;
              dir_x_d = 1'b1;
              hit_x_d = 1'b1;
            end else begin
              box_x_d = box_x_q - XW'(speed_x);
            end
          end
        end
      end

      STEP_Y: begin
        state_d = RECOLOR;
        hit_y_d = 1'b0;
        if (speed_y != 4'd0) begin
          if (dir_y_q) begin
            if (sum_y >= YMAX) begin
              box_y_d = YMAX[YW-1:0];
              dir_y_d = 1'b0;
              hit_y_d = 1'b1;
            end else begin
              box_y_d = sum_y[YW-1:0];
            end
          end else begin
            if ({1'b0, box_y_q} <= spd_y_ext) begin
              box_y_d = '0;
              dir_y_d = 1'b1;
              hit_y_d = 1'b1;
            end else begin
              box_y_d = box_y_q - YW'(speed_y);
            end
          end
        end
      end

      RECOLOR: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // Colour cycles 001..111, skipping black; a corner hit counts once.
        if (hit_x_q || hit_y_q)
          color_d = (color_q == 3'b111) ? 3'b001 : color_q + 3'd1;
      end

      default: state_d = IDLE;
    endcase
  end

  assign box_x       = box_x_q;
  assign box_y       = box_y_q;
  assign color       = color_q;
  assign busy        = (state_q != IDLE);
  assign update_done = done_q;

endmodule
